// File: rtl/countdown_pkg.sv
// Shared types and constants for the BCD minutes:seconds countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t  BCD_NINE     = 4'd9;
  localparam bcd_digit_t  SEC_TENS_MAX = 4'd5;
  localparam logic [15:0] ZERO_TIME    = 16'h0000;
  localparam logic [15:0] ONE_SECOND   = 16'h0001;

  // Saturate a preset digit to the largest legal value for its position.
  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d, input bcd_digit_t max_d);
    bcd_digit_t r;
    if (d > max_d) begin
      r = max_d;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the countdown timer and its driver.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic [7:0] loadMinutes;
  logic [7:0] loadSeconds;
  logic       start;
  logic       stop;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       running;
  logic       expired;
  logic       expiredPulse;

  modport slave (
    input  tick, load, loadMinutes, loadSeconds, start, stop,
    output minutes, seconds, running, expired, expiredPulse
  );

  modport master (
    output tick, load, loadMinutes, loadSeconds, start, stop,
    input  minutes, seconds, running, expired, expiredPulse
  );
endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MODULUS_MAX and emits a borrow.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter bcd_digit_t MODULUS_MAX = BCD_NINE
) (
  input  logic       inputClock,
  input  logic       reset,
  input  logic       enable,
  input  logic       borrowIn,
  input  logic       load,
  input  bcd_digit_t value,
  output bcd_digit_t digit,
  output logic       borrowOut
);

  bcd_digit_t digit_q;
  logic       dec_s;

  assign dec_s     = enable & borrowIn;
  assign borrowOut = dec_s & (digit_q == 4'd0);
  assign digit     = digit_q;

  always_ff @(posedge inputClock) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else if (load) begin
      digit_q <= value;
    end else if (dec_s) begin
      digit_q <= (digit_q == 4'd0) ? MODULUS_MAX : (digit_q - 4'd1);
    end else begin
      digit_q <= digit_q;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with start/stop control and expiry alarm.
// Optional COUNTDOWN_AUTO_RELOAD_EN reloads the last preset on expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter logic [7:0] MAX_MINUTES = 8'h99
) (
  input logic              inputClock,
  input logic              reset,
  countdown_timer_if.slave bus
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_RUNNING = ST_RUNNING;
  localparam logic [1:0] S_PAUSED  = ST_PAUSED;
  localparam logic [1:0] S_EXPIRED = ST_EXPIRED;

  logic [1:0]  state_q, state_d;
  logic        running_q, expired_q, pulse_q, pulse_d;
  logic [15:0] value_s, preset_s, ld_val_s, reload_val_s;
  logic [7:0]  san_min_s, san_sec_s;
  logic        ld_s, dec_s, reload_ok_s;
  logic        b_so_s, b_st_s, b_mo_s, b_mt_s;

  always_comb begin
    san_min_s = {bcd_sat(bus.loadMinutes[7:4], BCD_NINE), bcd_sat(bus.loadMinutes[3:0], BCD_NINE)};
    san_sec_s = {bcd_sat(bus.loadSeconds[7:4], SEC_TENS_MAX), bcd_sat(bus.loadSeconds[3:0], BCD_NINE)};
    // Valid BCD compares correctly as plain binary.
    if (san_min_s > MAX_MINUTES) begin
      preset_s = {MAX_MINUTES, san_sec_s};
    end else begin
      preset_s = {san_min_s, san_sec_s};
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] shadow_q;

  always_ff @(posedge inputClock) begin
    if (reset) begin
      shadow_q <= ZERO_TIME;
    end else if (bus.load) begin
      shadow_q <= preset_s;
    end else begin
      shadow_q <= shadow_q;
    end
  end

  assign reload_ok_s  = (shadow_q != ZERO_TIME);
  assign reload_val_s = shadow_q;
`else
  assign reload_ok_s  = 1'b0;
  assign reload_val_s = ZERO_TIME;
`endif

  always_comb begin
    state_d  = state_q;
    ld_s     = 1'b0;
    ld_val_s = preset_s;
    dec_s    = 1'b0;
    pulse_d  = 1'b0;
    if (bus.load) begin
      ld_s    = 1'b1;
      state_d = S_IDLE;
    end else if (bus.stop) begin
      case (state_q)
        S_RUNNING: state_d = S_PAUSED;
        S_EXPIRED: state_d = S_IDLE;
        default:   state_d = state_q;
      endcase
    end else if (bus.start) begin
      if (((state_q == S_IDLE) || (state_q == S_PAUSED)) && (value_s != ZERO_TIME)) begin
        state_d = S_RUNNING;
      end else begin
        state_d = state_q;
      end
    end else if (bus.tick && (state_q == S_RUNNING)) begin
      // Running never holds 00:00, so expiry is exactly a tick at 00:01.
      pulse_d = (value_s == ONE_SECOND);
      if ((value_s == ONE_SECOND) && reload_ok_s) begin
        ld_s     = 1'b1;
        ld_val_s = reload_val_s;
      end else begin
        dec_s = 1'b1;
        if (value_s == ONE_SECOND) begin
          state_d = S_EXPIRED;
        end else begin
          state_d = state_q;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge inputClock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUNNING);
      expired_q <= (state_d == S_EXPIRED);
      pulse_q   <= pulse_d;
    end
  end

  bcd_down_digit #(.MODULUS_MAX(BCD_NINE)) u_sec_ones (
    .inputClock(inputClock), .reset(reset), .enable(dec_s), .borrowIn(1'b1),
    .load(ld_s), .value(ld_val_s[3:0]), .digit(value_s[3:0]), .borrowOut(b_so_s)
  );

  bcd_down_digit #(.MODULUS_MAX(SEC_TENS_MAX)) u_sec_tens (
    .inputClock(inputClock), .reset(reset), .enable(dec_s), .borrowIn(b_so_s),
    .load(ld_s), .value(ld_val_s[7:4]), .digit(value_s[7:4]), .borrowOut(b_st_s)
  );

  bcd_down_digit #(.MODULUS_MAX(BCD_NINE)) u_min_ones (
    .inputClock(inputClock), .reset(reset), .enable(dec_s), .borrowIn(b_st_s),
    .load(ld_s), .value(ld_val_s[11:8]), .digit(value_s[11:8]), .borrowOut(b_mo_s)
  );

  bcd_down_digit #(.MODULUS_MAX(BCD_NINE)) u_min_tens (
    .inputClock(inputClock), .reset(reset), .enable(dec_s), .borrowIn(b_mo_s),
    .load(ld_s), .value(ld_val_s[15:12]), .digit(value_s[15:12]), .borrowOut(b_mt_s)
  );

  assign bus.minutes      = value_s[15:8];
  assign bus.seconds      = value_s[7:0];
  assign bus.running      = running_q;
  assign bus.expired      = expired_q;
  assign bus.expiredPulse = pulse_q;

endmodule
